// File: rtl/axis_channel_mux.sv
// -----------------------------------------------------------------------------
// axis_channel_mux
//
// Routes one of NUM_CHANNELS AXI-Stream slave inputs to a single registered
// AXI-Stream master output. The routed channel (active_ch) follows the sel
// input. In packet mode a switch is deferred while a packet is in flight and
// taken on the edge that accepts that packet's last beat.
//
// Parameters
//   DATA_WIDTH      sample width in bits per channel
//   NUM_CHANNELS    number of slave inputs (2..16)
//   PACKET_MODE     0: switch on any beat boundary, 1: only between packets
//   DROP_UNSELECTED 1: unselected inputs held ready and their beats discarded
//                   0: unselected inputs back-pressured
//
// Ports
//   aclk            clock, rising edge
//   areset          synchronous active-high reset
//   sel             requested channel index (values >= NUM_CHANNELS ignored)
//   s_axis_tdata    flattened inputs, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tvalid   per-channel valid
//   s_axis_tlast    per-channel end of packet
//   s_axis_tready   per-channel ready
//   m_axis_tdata    registered output data
//   m_axis_tvalid   registered output valid
//   m_axis_tlast    registered output end of packet
//   m_axis_tready   downstream ready
//   active_ch       currently routed channel
//   switch_pending  sel differs from active_ch and the switch is deferred
// -----------------------------------------------------------------------------
module axis_channel_mux #(
    parameter int DATA_WIDTH      = 16,
    parameter int NUM_CHANNELS    = 2,
    parameter int PACKET_MODE     = 0,
    parameter int DROP_UNSELECTED = 1,
    localparam int SEL_WIDTH      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                               aclk,
    input  logic                               areset,
    input  logic [SEL_WIDTH-1:0]               sel,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_CHANNELS-1:0]            s_axis_tvalid,
    input  logic [NUM_CHANNELS-1:0]            s_axis_tlast,
    output logic [NUM_CHANNELS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]              m_axis_tdata,
    output logic                               m_axis_tvalid,
    output logic                               m_axis_tlast,
    input  logic                               m_axis_tready,
    output logic [SEL_WIDTH-1:0]               active_ch,
    output logic                               switch_pending
);

    typedef enum logic [0:0] {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic UNSEL_READY = (DROP_UNSELECTED != 0) ? 1'b1 : 1'b0;
    localparam logic PKT_MODE    = (PACKET_MODE != 0) ? 1'b1 : 1'b0;

    state_t                 state_r;
    logic [DATA_WIDTH-1:0]  data_r;
    logic                   last_r;
    logic                   valid_r;
    logic [SEL_WIDTH-1:0]   active_r;
    logic                   in_packet_r;

    logic                   load_s;
    logic                   sel_ok_s;
    logic                   want_switch_s;
    logic                   locked_s;
    logic                   accept_s;
    logic                   do_switch_s;
    logic                   nxt_in_packet_s;
    logic [DATA_WIDTH-1:0]  act_data_s;
    logic                   act_valid_s;
    logic                   act_last_s;
    logic [31:0]            sel_ext_s;

    assign m_axis_tdata  = data_r;
    assign m_axis_tlast  = last_r;
    assign m_axis_tvalid = valid_r;
    assign active_ch     = active_r;

    // Select the routed channel's data, valid and last.
    always_comb begin
        act_data_s  = {DATA_WIDTH{1'b0}};
        act_valid_s = 1'b0;
        act_last_s  = 1'b0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (active_r == SEL_WIDTH'(k)) begin
                act_data_s  = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
                act_valid_s = s_axis_tvalid[k];
                act_last_s  = s_axis_tlast[k];
            end else begin
                act_data_s  = act_data_s;
            end
        end
    end

    // Handshake, switch decision and next packet-tracking value.
    always_comb begin
        load_s          = ~valid_r | m_axis_tready;
        sel_ext_s       = {{(32-SEL_WIDTH){1'b0}}, sel};
        sel_ok_s        = (sel_ext_s < 32'(NUM_CHANNELS));
        want_switch_s   = sel_ok_s & (sel != active_r);
        locked_s        = (state_r == ST_LOCKED);
        accept_s        = ~areset & load_s & act_valid_s;
        // A locked channel may still hand over on the edge that takes its last beat.
        do_switch_s     = want_switch_s & (~locked_s | (accept_s & act_last_s));
        switch_pending  = locked_s & want_switch_s;
        if (accept_s) begin
            nxt_in_packet_s = ~act_last_s;
        end else begin
            nxt_in_packet_s = in_packet_r;
        end
    end

    // Per-channel ready: routed channel follows load, others drop or stall; all low in reset.
    always_comb begin
        s_axis_tready = {NUM_CHANNELS{1'b0}};
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (areset) begin
                s_axis_tready[k] = 1'b0;
            end else if (active_r == SEL_WIDTH'(k)) begin
                s_axis_tready[k] = load_s;
            end else begin
                s_axis_tready[k] = UNSEL_READY;
            end
        end
    end

    // Output register, packet tracking, routing state and channel selection.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r     <= ST_OPEN;
            data_r      <= {DATA_WIDTH{1'b0}};
            last_r      <= 1'b0;
            valid_r     <= 1'b0;
            active_r    <= {SEL_WIDTH{1'b0}};
            in_packet_r <= 1'b0;
        end else begin
            // When the register is stalled downstream it must not change at all.
            if (load_s) begin
                valid_r <= accept_s;
                if (accept_s) begin
                    data_r <= act_data_s;
                    last_r <= act_last_s;
                end
            end
            in_packet_r <= nxt_in_packet_s;
            state_r     <= (PKT_MODE & nxt_in_packet_s) ? ST_LOCKED : ST_OPEN;
            // The beat accepted in the switching cycle belongs to the old channel.
            if (do_switch_s) begin
                active_r <= sel;
            end
        end
    end

endmodule

// File: tb/tb_axis_channel_mux.sv
module tb_axis_channel_mux;

    logic        aclk = 1'b0;
    logic        areset;
    logic [1:0]  sel;
    logic [63:0] tdata;
    logic [3:0]  tvalid;
    logic [3:0]  tlast;
    logic        mready;

    logic [15:0] o_data [3];
    logic        o_valid[3];
    logic        o_last [3];
    logic [1:0]  o_act  [3];
    logic        o_pend [3];
    logic [3:0]  rdy0, rdy1;
    logic [2:0]  rdy2;

    int tests = 0;
    int fails = 0;

    // reference model state per instance
    int          m_n   [3] = '{4, 4, 3};
    bit          m_pm  [3] = '{1'b0, 1'b1, 1'b1};
    bit          m_drop[3] = '{1'b1, 1'b0, 1'b1};
    int          m_act [3] = '{0, 0, 0};
    bit          m_inpkt[3] = '{1'b0, 1'b0, 1'b0};
    bit          m_occ [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] m_data[3] = '{16'h0, 16'h0, 16'h0};
    bit          m_last[3] = '{1'b0, 1'b0, 1'b0};

    always #5 aclk = ~aclk;

    axis_channel_mux #(.DATA_WIDTH(16), .NUM_CHANNELS(4), .PACKET_MODE(0), .DROP_UNSELECTED(1)) u0 (
        .aclk(aclk), .areset(areset), .sel(sel),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tready(rdy0),
        .m_axis_tdata(o_data[0]), .m_axis_tvalid(o_valid[0]), .m_axis_tlast(o_last[0]),
        .m_axis_tready(mready), .active_ch(o_act[0]), .switch_pending(o_pend[0]));

    axis_channel_mux #(.DATA_WIDTH(16), .NUM_CHANNELS(4), .PACKET_MODE(1), .DROP_UNSELECTED(0)) u1 (
        .aclk(aclk), .areset(areset), .sel(sel),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tready(rdy1),
        .m_axis_tdata(o_data[1]), .m_axis_tvalid(o_valid[1]), .m_axis_tlast(o_last[1]),
        .m_axis_tready(mready), .active_ch(o_act[1]), .switch_pending(o_pend[1]));

    axis_channel_mux #(.DATA_WIDTH(16), .NUM_CHANNELS(3), .PACKET_MODE(1), .DROP_UNSELECTED(1)) u2 (
        .aclk(aclk), .areset(areset), .sel(sel),
        .s_axis_tdata(tdata[47:0]), .s_axis_tvalid(tvalid[2:0]), .s_axis_tlast(tlast[2:0]),
        .s_axis_tready(rdy2),
        .m_axis_tdata(o_data[2]), .m_axis_tvalid(o_valid[2]), .m_axis_tlast(o_last[2]),
        .m_axis_tready(mready), .active_ch(o_act[2]), .switch_pending(o_pend[2]));

    function automatic logic [3:0] dut_rdy(input int i);
        case (i)
            0:       return rdy0;
            1:       return rdy1;
            default: return {1'b0, rdy2};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [15:0] d, input logic v, input logic l);
        tdata[k*16 +: 16] = d;
        tvalid[k]         = v;
        tlast[k]          = l;
    endtask

    // One clock cycle: check combinational outputs against the model, advance
    // the model by the stream rules, then check the registered outputs.
    task automatic step();
        logic [3:0]  er;
        bit          ld, acc, ok, lin, lk, ep;
        logic [15:0] din;
        int          nact;
        #1;
        for (int i = 0; i < 3; i++) begin
            ld = !m_occ[i] || mready;
            er = 4'b0000;
            for (int k = 0; k < m_n[i]; k++)
                er[k] = areset ? 1'b0 : ((k == m_act[i]) ? ld : m_drop[i]);
            check($sformatf("tready_u%0d", i), 32'(dut_rdy(i)), 32'(er));
            ok = (int'(sel) < m_n[i]);
            ep = m_pm[i] && m_inpkt[i] && ok && (int'(sel) != m_act[i]);
            check($sformatf("pending_u%0d", i), 32'(o_pend[i]), 32'(ep));
        end
        for (int i = 0; i < 3; i++) begin
            if (areset) begin
                m_occ[i] = 1'b0; m_data[i] = 16'h0; m_last[i] = 1'b0;
                m_act[i] = 0;    m_inpkt[i] = 1'b0;
            end else begin
                ld   = !m_occ[i] || mready;
                acc  = ld && tvalid[m_act[i]];
                din  = tdata[m_act[i]*16 +: 16];
                lin  = tlast[m_act[i]];
                ok   = (int'(sel) < m_n[i]);
                lk   = m_pm[i] && m_inpkt[i];
                nact = m_act[i];
                if (ok && int'(sel) != m_act[i] && (!lk || (acc && lin))) nact = int'(sel);
                if (ld) begin
                    m_occ[i] = acc;
                    if (acc) begin m_data[i] = din; m_last[i] = lin; end
                end
                if (acc) m_inpkt[i] = !lin;
                m_act[i] = nact;
            end
        end
        @(negedge aclk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("tvalid_u%0d", i), 32'(o_valid[i]), 32'(m_occ[i]));
            check($sformatf("active_u%0d", i), 32'(o_act[i]), 32'(m_act[i]));
            if (m_occ[i]) begin
                check($sformatf("tdata_u%0d", i), 32'(o_data[i]), 32'(m_data[i]));
                check($sformatf("tlast_u%0d", i), 32'(o_last[i]), 32'(m_last[i]));
            end
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        tvalid = 4'h0;
        tlast  = 4'h0;
        tdata  = 64'h0;
        mready = 1'b1;
        step();
        step();
        areset = 1'b0;
    endtask

    initial begin
        areset = 1'b1; sel = 2'd0; tdata = 64'h0; tvalid = 4'h0; tlast = 4'h0; mready = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        // reset state
        for (int i = 0; i < 3; i++) begin
            check("rst_valid", 32'(o_valid[i]), 32'd0);
            check("rst_data",  32'(o_data[i]),  32'd0);
            check("rst_last",  32'(o_last[i]),  32'd0);
            check("rst_act",   32'(o_act[i]),   32'd0);
            check("rst_pend",  32'(o_pend[i]),  32'd0);
        end
        do_reset();

        // switch on a beat boundary without losing the in-flight beat
        sel = 2'd0;
        set_ch(0, 16'd14, 1'b1, 1'b0);
        set_ch(1, 16'hFFE3, 1'b1, 1'b0);
        step(); step();
        check("sw_pre_data", 32'(o_data[0]), 32'd14);
        sel = 2'd1;
        step();
        check("sw_edge_data", 32'(o_data[0]), 32'd14);
        check("sw_edge_act",  32'(o_act[0]),  32'd1);
        step();
        check("sw_new_data",  32'(o_data[0]), 32'hFFE3);
        step();
        check("sw_new_data2", 32'(o_data[0]), 32'hFFE3);

        // packet mode: switch deferred until the last beat
        do_reset();
        sel = 2'd0;
        set_ch(2, 16'h0222, 1'b1, 1'b0);
        set_ch(0, 16'd1, 1'b1, 1'b0);
        step();
        check("pkt_b1", 32'(o_data[1]), 32'd1);
        set_ch(0, 16'd2, 1'b1, 1'b0);
        step();
        check("pkt_b2", 32'(o_data[1]), 32'd2);
        sel = 2'd2;
        set_ch(0, 16'd3, 1'b1, 1'b0);
        step();
        check("pkt_b3",      32'(o_data[1]), 32'd3);
        check("pkt_pend_b3", 32'(o_pend[1]), 32'd1);
        check("pkt_act_b3",  32'(o_act[1]),  32'd0);
        set_ch(0, 16'd4, 1'b1, 1'b1);
        step();
        check("pkt_b4",      32'(o_data[1]), 32'd4);
        check("pkt_last_b4", 32'(o_last[1]), 32'd1);
        check("pkt_act_b4",  32'(o_act[1]),  32'd2);
        check("pkt_pend_b4", 32'(o_pend[1]), 32'd0);
        set_ch(0, 16'd0, 1'b0, 1'b0);
        step();
        check("pkt_ch2", 32'(o_data[1]), 32'h0222);

        // backpressure: output held, routed ready low, no drop or duplicate
        do_reset();
        sel = 2'd0;
        set_ch(0, 16'd100, 1'b1, 1'b0);
        step();
        check("bp_first", 32'(o_data[0]), 32'd100);
        mready = 1'b0;
        set_ch(0, 16'd101, 1'b1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_hold_data", 32'(o_data[0]),  32'd100);
            check("bp_hold_last", 32'(o_last[0]),  32'd0);
            check("bp_hold_vld",  32'(o_valid[0]), 32'd1);
            check("bp_ready0",    32'(rdy0[0]),    32'd0);
        end
        mready = 1'b1;
        step();
        check("bp_resume1", 32'(o_data[0]), 32'd101);
        check("bp_resume1_last", 32'(o_last[0]), 32'd1);
        set_ch(0, 16'd102, 1'b1, 1'b0);
        step();
        check("bp_resume2", 32'(o_data[0]), 32'd102);

        // unselected channel 3: dropped (u0) vs back-pressured (u1)
        do_reset();
        sel = 2'd0;
        set_ch(0, 16'h0055, 1'b1, 1'b0);
        set_ch(3, 16'hDEAD, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            step();
            check("drop1_rdy3", 32'(rdy0[3]), 32'd1);
            check("drop0_rdy3", 32'(rdy1[3]), 32'd0);
            check("no_ch3_u0",  32'(o_data[0] == 16'hDEAD), 32'd0);
            check("no_ch3_u1",  32'(o_data[1] == 16'hDEAD), 32'd0);
        end

        // out-of-range sel on the 3-channel instance
        do_reset();
        sel = 2'd1;
        set_ch(1, 16'h0111, 1'b1, 1'b0);
        step(); step();
        check("oor_pre_act", 32'(o_act[2]), 32'd1);
        sel = 2'd3;
        for (int c = 0; c < 3; c++) begin
            step();
            check("oor_act",  32'(o_act[2]),  32'd1);
            check("oor_pend", 32'(o_pend[2]), 32'd0);
        end

        // reset mid-packet, then a new sel honoured right after release
        do_reset();
        sel = 2'd0;
        set_ch(0, 16'h0AAA, 1'b1, 1'b0);
        set_ch(1, 16'h0BBB, 1'b1, 1'b0);
        step(); step();
        sel = 2'd1;
        step();
        check("mid_pend", 32'(o_pend[1]), 32'd1);
        check("mid_act",  32'(o_act[1]),  32'd0);
        areset = 1'b1;
        step();
        check("mid_rst_vld",  32'(o_valid[1]), 32'd0);
        check("mid_rst_act",  32'(o_act[1]),   32'd0);
        check("mid_rst_pend", 32'(o_pend[1]),  32'd0);
        areset = 1'b0;
        step();
        check("post_rst_act", 32'(o_act[1]), 32'd1);
        step();
        check("post_rst_data", 32'(o_data[1]), 32'h0BBB);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            tdata  = {$urandom, $urandom};
            tvalid = 4'($urandom_range(15));
            for (int k = 0; k < 4; k++) tlast[k] = ($urandom_range(3) == 0);
            mready = ($urandom_range(3) != 0);
            if ($urandom_range(7) == 0) sel = 2'($urandom_range(3));
            areset = ($urandom_range(63) == 0);
            step();
        end
        areset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
